// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } md_state_e;

    localparam int ITER = 32;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply or restoring divide.
// The divide leg is present only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic         is_div_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] sr_i,
    input  logic [W-1:0] opnd_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] sr_o
);

    logic [W:0] sum;
`ifdef MULDIV_DIV_EN
    logic [W:0] sh;
    logic [W:0] diff;
`else
    logic unused_div;
    assign unused_div = is_div_i;
`endif

    always_comb begin
        // Multiply: add to the upper half, then shift {acc, multiplier} right.
        sum   = {1'b0, acc_i} + {1'b0, (sr_i[0] ? opnd_i : {W{1'b0}})};
        acc_o = sum[W:1];
        sr_o  = {sum[0], sr_i[W-1:1]};
`ifdef MULDIV_DIV_EN
        sh   = {acc_i, sr_i[W-1]};
        diff = sh - {1'b0, opnd_i};
        if (is_div_i) begin
            if (sh >= {1'b0, opnd_i}) begin
                acc_o = diff[W-1:0];
                sr_o  = {sr_i[W-2:0], 1'b1};
            end else begin
                acc_o = sh[W-1:0];
                sr_o  = {sr_i[W-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: 32-iteration multiply/divide FSM with pipeline stall request.
// MULDIV_DIV_EN enables DIV/DIVU; otherwise divide starts are dropped.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hilo_rd_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_req_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, sr_q, sr_d, opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, sgn_q, sgn_d, dneg_q, dneg_d;
    logic             done_q, done_d, dz_q, dz_d;

    logic [WIDTH-1:0]   acc_nx, sr_nx, abs_a, abs_b, rem_fix, quo_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic               signed_op, a_neg, b_neg, accept;

    muldiv_step #(.W(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .sr_i     (sr_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_nx),
        .sr_o     (sr_nx)
    );

    assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign a_neg     = signed_op & a_i[WIDTH-1];
    assign b_neg     = signed_op & b_i[WIDTH-1];
    assign abs_a     = a_neg ? -a_i : a_i;
    assign abs_b     = b_neg ? -b_i : b_i;
    assign accept    = (state_q == IDLE) & start_i & ~flush_i & (DIV_EN | ~op_i[1]);

    // A zero divisor leaves |a| in the remainder, so the dividend-sign
    // correction below restores the raw a for HI.
    assign prod     = {acc_q, sr_q};
    assign prod_fix = sgn_q ? -prod : prod;
    assign rem_fix  = dneg_q ? -acc_q : acc_q;
    assign quo_fix  = sgn_q ? -sr_q : sr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sr_d     = sr_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        dneg_d   = dneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (accept) begin
                    is_div_d = op_i[1] & DIV_EN;
                    sgn_d    = a_neg ^ b_neg;
                    dneg_d   = a_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    sr_d     = op_i[1] ? abs_a : abs_b;
                    opnd_d   = op_i[1] ? abs_b : abs_a;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_nx;
                    sr_d  = sr_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (opnd_q == '0) begin
                        hi_d = rem_fix;
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sr_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            dneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            dneg_q   <= dneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign stall_req_o = busy_o & (start_i | hilo_rd_i | hi_we_i | lo_we_i);
    assign done_o      = done_q;
    assign div_zero_o  = dz_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed checks for muldiv_sequencer; divide vectors run only with MULDIV_DIV_EN.
module tb_muldiv_sequencer;

    logic        clk, rst_n, start, hilo_rd, hi_we, lo_we, flush;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, stall_req, done, div_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .hilo_rd_i   (hilo_rd),
        .hi_we_i     (hi_we),
        .lo_we_i     (lo_we),
        .wdata_i     (wdata),
        .flush_i     (flush),
        .busy_o      (busy),
        .stall_req_o (stall_req),
        .done_o      (done),
        .div_zero_o  (div_zero),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count busy cycles, then check HI/LO in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk({tag, ".busy_cycles"}, 64'(n), 64'd33);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".hi"}, 64'(hi), 64'(ehi));
        chk({tag, ".lo"}, 64'(lo), 64'(elo));
        tick();
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int k, nst, seen;
        rst_n = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        hilo_rd = 1'b1;
        #1;
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dz", 64'(div_zero), 64'd0);
        chk("rst.stall", 64'(stall_req), 64'd0);
        hilo_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("mult_pos", 2'b00, 32'd123456, 32'd1000, 32'h0, 32'h075B_CA00);
        run_op("mult_m1m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);

        // MTHI together with an accepted start: write lands, result overwrites later.
        hi_we = 1'b1; wdata = 32'h55; start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        tick();
        hi_we = 1'b0; start = 1'b0;
        chk("we_start.hi", 64'(hi), 64'h55);
        chk("we_start.busy", 64'(busy), 64'd1);
        k = 0;
        while (busy && k < 40) begin k++; tick(); end
        chk("we_start.res_hi", 64'(hi), 64'd0);
        chk("we_start.res_lo", 64'(lo), 64'd6);
        tick();

        // Flush in the same cycle as start in IDLE.
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start.busy", 64'(busy), 64'd0);

        // MFLO during the run stalls; start while busy is ignored.
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        tick();
        start = 1'b0;
        k = 0; nst = 0;
        while (busy && k < 40) begin
            start = (k == 5);
            if (k == 5) begin op = 2'b01; a = 32'd2; b = 32'd2; end
            if (k >= 10) hilo_rd = 1'b1;
            #1;
            if (k == 5) chk("busy_start.stall", 64'(stall_req), 64'd1);
            if (hilo_rd && stall_req) nst++;
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        chk("rd.stall_cycles", 64'(nst), 64'd23);
        chk("rd.done_stall", 64'(stall_req), 64'd0);
        chk("rd.done", 64'(done), 64'd1);
        chk("rd.lo", 64'(lo), 64'd42);
        hilo_rd = 1'b0;
        tick();
        chk("busy_start.dropped", 64'(busy), 64'd0);

        // MTHI/MTLO preload, then flush a MULTU mid-run.
        hi_we = 1'b1; wdata = 32'h11;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        tick();
        lo_we = 1'b0;
        chk("mt.hi", 64'(hi), 64'h11);
        chk("mt.lo", 64'(lo), 64'h22);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
        tick();
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        chk("flush.no_done", 64'(seen), 64'd0);
        chk("flush.hi", 64'(hi), 64'h11);
        chk("flush.lo", 64'(lo), 64'h22);

`ifdef MULDIV_DIV_EN
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        run_op("div_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);
        run_op("div_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        chk("dz.set", 64'(div_zero), 64'd1);
        run_op("div_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        chk("dz.set2", 64'(div_zero), 64'd1);
        run_op("mult_after_dz", 2'b00, 32'd2, 32'd2, 32'd0, 32'd4);
        chk("dz.cleared", 64'(div_zero), 64'd0);
`else
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        chk("nodiv.busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            tick();
        end
        chk("nodiv.idle", 64'(seen), 64'd0);
        chk("nodiv.hi", 64'(hi), 64'h11);
        chk("nodiv.lo", 64'(lo), 64'h22);
        chk("nodiv.dz", 64'(div_zero), 64'd0);
`endif

        // Asynchronous reset mid-run clears everything immediately.
        start = 1'b1; op = 2'b01; a = 32'hFFFF; b = 32'hFFFF;
        tick();
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("prereset.busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        chk("arst.hi", 64'(hi), 64'd0);
        chk("arst.lo", 64'(lo), 64'd0);
        chk("arst.dz", 64'(div_zero), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postreset.busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
